// File: rtl/alu_sequencer_pkg.sv
// Shared encodings and constants for the Ed25519 ALU command sequencer.
// Also holds the ALU's internal counter limits, which a cycle model needs.
package alu_sequencer_pkg;

  localparam int SCALAR_W = 255;
  localparam int IDX_W    = 8;

  // 2^255 - 21 (q - 2) and q = 2^255 - 19
  localparam logic [SCALAR_W-1:0] INV_EXP = {{250{1'b1}}, 5'b01011};
  localparam logic [255:0]        Q       = {1'b0, {250{1'b1}}, 5'b01101};

  localparam int PRE_CNT_MAX = 7;
  localparam int DBL_CNT_MAX = 13;
  localparam int ADD_CNT_MAX = 12;
  localparam int INV_CNT_MAX = 7;
  localparam int MUL_CNT_MAX = 5;

  typedef enum logic [1:0] {
    ALU_PRE_CAL = 2'd0,
    ALU_DOUBLE  = 2'd1,
    ALU_DIV_INV = 2'd2,
    ALU_DIV_MUL = 2'd3
  } alu_cmd_e;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_PRE    = 3'd1,
    PH_LADDER = 3'd2,
    PH_INV    = 3'd3,
    PH_MUL    = 3'd4
  } phase_e;

  typedef enum logic [3:0] {
    S_IDLE, S_ISS_PRE, S_WT_PRE, S_ISS_LAD, S_WT_LAD,
    S_ISS_INV, S_WT_INV, S_ISS_MUL, S_WT_MUL, S_DONE
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Command-side sequencer for the Ed25519 ALU: PRE-CAL, 255-bit ladder,
// 255-step inversion, DIV-MUL, all constant-time regardless of the scalar.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SCALAR_W-1:0] scalar,
  input  logic                alu_ready,
  output logic                alu_valid,
  output logic [1:0]          alu_state,
  output logic                alu_keep_flag,
  output logic                alu_consecutive_flag,
  output logic                busy,
  output logic                done,
  output logic [2:0]          phase,
  output logic [IDX_W-1:0]    bit_idx,
  output logic                err
);

  seq_state_e          state_reg;
  logic [SCALAR_W-1:0] k_reg;
  logic                proto_err;

  // A ready is only legal while a group is outstanding (WT_x states).
  assign proto_err = alu_ready &&
                     (state_reg inside {S_IDLE, S_ISS_PRE, S_ISS_LAD,
                                        S_ISS_INV, S_ISS_MUL, S_DONE});

  always_comb begin
    alu_consecutive_flag = 1'b0;
    alu_keep_flag        = 1'b0;
    if (state_reg == S_WT_LAD) begin
      alu_consecutive_flag = k_reg[bit_idx];
      alu_keep_flag        = (bit_idx != '0);
    end else if (state_reg == S_WT_INV) begin
      alu_consecutive_flag = INV_EXP[bit_idx];
      alu_keep_flag        = (bit_idx != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      k_reg     <= '0;
      alu_valid <= 1'b0;
      alu_state <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      phase     <= PH_IDLE;
      bit_idx   <= '0;
      err       <= 1'b0;
    end else begin
      alu_valid <= 1'b0;
      done      <= 1'b0;

      if (state_reg == S_IDLE && start) err <= 1'b0;
      else if (proto_err)               err <= 1'b1;

      case (state_reg)
        S_IDLE: if (start) begin
          k_reg     <= scalar;
          busy      <= 1'b1;
          phase     <= PH_PRE;
          alu_valid <= 1'b1;
          alu_state <= ALU_PRE_CAL;
          state_reg <= S_ISS_PRE;
        end
        S_ISS_PRE: state_reg <= S_WT_PRE;
        S_WT_PRE: if (alu_ready) begin
          phase     <= PH_LADDER;
          alu_valid <= 1'b1;
          alu_state <= ALU_DOUBLE;
          bit_idx   <= IDX_W'(SCALAR_W - 1);
          state_reg <= S_ISS_LAD;
        end
        S_ISS_LAD: state_reg <= S_WT_LAD;
        S_WT_LAD: if (alu_ready) begin
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - IDX_W'(1);
          end else begin
            phase     <= PH_INV;
            alu_valid <= 1'b1;
            alu_state <= ALU_DIV_INV;
            bit_idx   <= IDX_W'(SCALAR_W - 1);
            state_reg <= S_ISS_INV;
          end
        end
        S_ISS_INV: state_reg <= S_WT_INV;
        S_WT_INV: if (alu_ready) begin
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - IDX_W'(1);
          end else begin
            phase     <= PH_MUL;
            alu_valid <= 1'b1;
            alu_state <= ALU_DIV_MUL;
            state_reg <= S_ISS_MUL;
          end
        end
        S_ISS_MUL: state_reg <= S_WT_MUL;
        S_WT_MUL: if (alu_ready) begin
          done      <= 1'b1;
          state_reg <= S_DONE;
        end
        S_DONE: begin
          busy      <= 1'b0;
          phase     <= PH_IDLE;
          alu_state <= 2'd0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-side controller for the Ed25519 ALU: owns the `in_valid/in_state/in_keep_flag/in_consecutive_flag` side of the ALU command interface and consumes its `out_ready`. On `start` it runs these ALU command groups, constant-time, with no data-dependent skipping:
- PRE-CAL.
- A 255-bit MSB-first double-and-add ladder over the latched scalar.
- A 255-step square-and-multiply inversion with exponent q−2.
- DIV-MUL.

It sits between the top-level handshake and the ALU; it holds no field data.

## Interface
- `SCALAR_W`, 255: scalar and exponent width.
- `INV_EXP`, 255'h7FFF…FFEB (2^255−21 = q−2): inversion exponent, MSB-first.
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `start` in 1: begin a job. Sampled only in IDLE.
- `scalar` in 255: scalar k, latched on accepted `start`.
- `alu_ready` in 1: ALU `out_ready`.
- `alu_valid` out 1: ALU `in_valid`. One-cycle pulse per command group.
- `alu_state` out 2: ALU `in_state`. 0 PRE-CAL, 1 DOUBLE, 2 DIV-INV, 3 DIV-MUL.
- `alu_keep_flag` out 1: ALU `in_keep_flag`.
- `alu_consecutive_flag` out 1: ALU `in_consecutive_flag`.
- `busy` out 1: high from accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse, the cycle after the final `alu_ready`.
- `phase` out 3: 0 IDLE, 1 PRE, 2 LADDER, 3 INV, 4 MUL. Read by the register file for preloads.
- `bit_idx` out 8: current ladder/exponent bit index (254..0).
- `err` out 1: sticky protocol error. Cleared only by `rst` or by an accepted `start`.

## Operation
- FSM states: IDLE, ISS_PRE, WT_PRE, ISS_LAD, WT_LAD, ISS_INV, WT_INV, ISS_MUL, WT_MUL, DONE.
- Each ISS_x state:
  - lasts exactly one cycle;
  - drives `alu_valid`=1 and `alu_state` for the group;
  - loads `bit_idx`=254 for LAD/INV.
- Each WT_x state waits for `alu_ready`.
- WT_LAD:
  - `alu_consecutive_flag` = k[bit_idx];
  - `alu_keep_flag` = (bit_idx≠0);
  - on `alu_ready`: if bit_idx≠0, decrement bit_idx; else go to ISS_INV.
  - The ALU internally chains DOUBLE→ADDITION→DOUBLE; exactly one `alu_ready` arrives per bit.
- WT_INV:
  - `alu_consecutive_flag` = INV_EXP[bit_idx] (1: multiply by Z; 0: multiply by 1);
  - `alu_keep_flag` = (bit_idx≠0);
  - `alu_ready` handling is the same as WT_LAD; exits to ISS_MUL.
- WT_PRE/WT_MUL: on a single `alu_ready`, advance to the next ISS state or to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Flags are combinational from `bit_idx`, the latched k and the state. They are 0 outside WT_LAD/WT_INV.
- `start` while `busy`: ignored; k is not re-latched.
- `alu_ready` in IDLE, ISS_x or DONE: set `err`, otherwise ignored.
- Reset mid-job, asynchronous:
  - FSM returns to IDLE immediately;
  - every output goes to 0, including `bit_idx`;
  - the latched scalar is cleared.

## Timing
- Reset values: all outputs 0.
- Accepted `start` at cycle S:
  - ISS_PRE at S+1;
  - PRE ready at S+9;
  - ISS_LAD at S+10.
- The ladder takes 14 cycles per bit plus 13 per set bit. With w = popcount(k), LAD ready (bit 0) arrives at S+3580+13w.
- ISS_INV at S+3581+13w; INV takes 8 cycles/step × 255 steps.
- ISS_MUL at S+5622+13w.
- `done` at S+5629+13w.
- Next `start` is accepted on the cycle after `done`.
- Per group, `alu_valid` is never asserted while the sequencer is awaiting `alu_ready`.

## Structure
- Shared package holds:
  - ALU command encodings (PRE_CAL=0, DOUBLE=1, DIV_INV=2, DIV_MUL=3);
  - the `phase` encodings;
  - `INV_EXP` and q;
  - width constants.
- The ALU's internal counter limits (PRE 7, DOUBLE 13, ADD 12, INV 7, MUL 5) also go in the package, for the bench's cycle model.
- Single flat module; no sub-module. The bit-index counter and FSM are small enough.

## Test plan
- k=0, ALU model responding per its cycle counts → `alu_consecutive_flag` 0 for all 255 ladder bits, `done` at S+5629, `err`=0.
- k=1 → consecutive=1 only while bit_idx=0, `done` at S+5642.
- k=2^255−1 → consecutive always 1 in LADDER, `done` at S+8944.
- INV exponent check → consecutive in WT_INV equals 1 at bit_idx 254..5, 3, 1, 0 and 0 at 4, 2; `alu_keep_flag` drops only at bit_idx=0.
- `start` pulsed at S+100 with a different scalar → ignored: flags still follow the original k, timing unchanged.
- `rst` asserted mid-LADDER → `busy`, `alu_valid`, `bit_idx` are 0 in the same cycle. A stray `alu_ready` in IDLE afterwards sets `err`=1; the next `start` clears it.
